// File: rtl/menu_key_pulser.sv
`default_nettype none
// ============================================================================
// Module   : menu_key_pulser
// Purpose  : Turns raw held key levels into debounced, arbitrated, one-cycle
//            active-low press/repeat pulses for the menu screen.
// Revision : 1.0 - initial release
// ============================================================================
module menu_key_pulser #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 7500000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic up_raw,
    input  logic down_raw,
    input  logic slct_raw,
    output logic up_keyN,
    output logic down_keyN,
    output logic slct_keyN
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_PRESS_DB = 3'd1;
    localparam logic [2:0] c_HELD     = 3'd2;
    localparam logic [2:0] c_REPEAT   = 3'd3;
    localparam logic [2:0] c_REL_DB   = 3'd4;

    localparam logic [CNT_W-1:0] c_DEB  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_RDLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] c_RPER = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] c_MAX  = '1;
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [2:0] w_raw;
    logic [2:0] r_meta;
    logic [2:0] r_sync;
    logic [2:0] w_req;
    logic       w_slct_lock;

    // Key order in the vectors: 0 = up, 1 = down, 2 = select
    assign w_raw = {slct_raw, down_raw, up_raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_key
        localparam bit c_CAN_REP = (k < 2);

        logic [2:0]       r_state;
        logic [2:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             r_rep;
        logic             w_rep_nxt;
        logic             r_arm;
        logic             w_arm_nxt;
        logic             r_req;
        logic             w_req_nxt;
        logic             w_s;

        assign w_s       = r_sync[k];
        assign w_cnt_inc = (r_cnt == c_MAX) ? r_cnt : r_cnt + c_ONE;
        assign w_req[k]  = r_req;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_rep_nxt   = r_rep;
            w_arm_nxt   = r_arm;
            w_req_nxt   = 1'b0;
            case (r_state)
                c_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_s) begin
                        w_state_nxt = c_PRESS_DB;
                        w_cnt_nxt   = c_ONE;
                    end else begin
                        // Arming needs a released key seen while enabled
                        w_arm_nxt = 1'b1;
                    end
                end
                c_PRESS_DB: begin
                    if (!w_s) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= c_DEB) begin
                        w_state_nxt = c_HELD;
                        w_cnt_nxt   = '0;
                        w_rep_nxt   = 1'b0;
                        w_req_nxt   = r_arm;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                c_HELD: begin
                    if (!w_s) begin
                        w_state_nxt = c_REL_DB;
                        w_cnt_nxt   = c_ONE;
                    end else if (c_CAN_REP && (r_cnt >= c_RDLY)) begin
                        w_state_nxt = c_REPEAT;
                        w_cnt_nxt   = '0;
                        w_rep_nxt   = 1'b1;
                        w_req_nxt   = r_arm;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                c_REPEAT: begin
                    if (!w_s) begin
                        w_state_nxt = c_REL_DB;
                        w_cnt_nxt   = c_ONE;
                    end else if (r_cnt >= c_RPER) begin
                        w_cnt_nxt = '0;
                        w_req_nxt = r_arm;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                c_REL_DB: begin
                    if (w_s) begin
                        w_state_nxt = r_rep ? c_REPEAT : c_HELD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= c_DEB) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
            if (!enable) begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
                w_rep_nxt   = 1'b0;
                w_arm_nxt   = 1'b0;
                w_req_nxt   = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_IDLE;
                r_cnt   <= '0;
                r_rep   <= 1'b0;
                r_arm   <= 1'b0;
                r_req   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_rep   <= w_rep_nxt;
                r_arm   <= w_arm_nxt;
                r_req   <= w_req_nxt;
            end
        end

        if (k == 2) begin : g_lock
            assign w_slct_lock = (r_state == c_HELD) || (r_state == c_REL_DB);
        end
    end

    // Gating on the current output level keeps every low pulse to one cycle
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            up_keyN   <= 1'b1;
            down_keyN <= 1'b1;
            slct_keyN <= 1'b1;
        end else begin
            slct_keyN <= !(w_req[2] && slct_keyN);
            up_keyN   <= !(w_req[0] && !w_req[1] && !w_req[2] && !w_slct_lock && up_keyN);
            down_keyN <= !(w_req[1] && !w_req[0] && !w_req[2] && !w_slct_lock && down_keyN);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_menu_key_pulser.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_key_pulser
// Purpose  : Directed-vector scoreboard bench for menu_key_pulser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_key_pulser;

    localparam int c_DEB  = 4;
    localparam int c_RDLY = 20;
    localparam int c_RPER = 8;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic up_raw;
    logic down_raw;
    logic slct_raw;
    logic up_keyN;
    logic down_keyN;
    logic slct_keyN;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    typedef struct {
        int key;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    menu_key_pulser #(
        .DEBOUNCE_CYCLES (c_DEB),
        .REPEAT_DELAY    (c_RDLY),
        .REPEAT_PERIOD   (c_RPER),
        .CNT_W           (8)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .up_raw    (up_raw),
        .down_raw  (down_raw),
        .slct_raw  (slct_raw),
        .up_keyN   (up_keyN),
        .down_keyN (down_keyN),
        .slct_keyN (slct_keyN)
    );

    task automatic expect_pulse(input int key, input int cyc);
        exp_t e;
        e.key = key;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_key(input int key, input logic v);
        exp_t e;
        if (v === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: key %0d low at edge %0d, required high", key, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                if (e.key != key || e.cyc != edge_cnt) begin
                    errors++;
                    $display("FAIL pulse_match: actual key %0d at edge %0d, required key %0d at edge %0d",
                             key, edge_cnt, e.key, e.cyc);
                end
            end
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({up_keyN, down_keyN, slct_keyN} !== 3'b111) begin
            errors++;
            $display("FAIL %s: actual keys %b, required 111", name, {up_keyN, down_keyN, slct_keyN});
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: actual %0d pending pulses, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: sampled 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse: key %0d expected at edge %0d, actual none", exp_q[0].key, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            check_key(0, up_keyN);
            check_key(1, down_keyN);
            check_key(2, slct_keyN);
        end
    end

    initial begin
        int b;
        bit bounce [7];
        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        reset    = 1'b1;
        enable   = 1'b1;
        up_raw   = 1'b0;
        down_raw = 1'b0;
        slct_raw = 1'b0;
        step(3);
        check_idle("reset_state");
        reset = 1'b0;
        step(5);

        // Single press
        b = edge_cnt + 1;
        up_raw = 1'b1;
        expect_pulse(0, b + 7);
        step(10);
        up_raw = 1'b0;
        step(20);
        check_drained("single_press");

        // Bounce rejection
        foreach (bounce[i]) begin
            down_raw = bounce[i];
            step(1);
        end
        down_raw = 1'b0;
        step(15);
        check_drained("bounce_reject");

        // Auto-repeat on down
        b = edge_cnt + 1;
        down_raw = 1'b1;
        expect_pulse(1, b + 7);
        expect_pulse(1, b + 28);
        expect_pulse(1, b + 37);
        expect_pulse(1, b + 46);
        expect_pulse(1, b + 55);
        step(60);
        down_raw = 1'b0;
        step(20);
        check_drained("down_repeat");

        // Select never repeats
        b = edge_cnt + 1;
        slct_raw = 1'b1;
        expect_pulse(2, b + 7);
        step(60);
        slct_raw = 1'b0;
        step(20);
        check_drained("slct_no_repeat");

        // Release glitch returns to HELD with the delay restarted
        b = edge_cnt + 1;
        up_raw = 1'b1;
        expect_pulse(0, b + 7);
        expect_pulse(0, b + 38);
        expect_pulse(0, b + 47);
        step(12);
        up_raw = 1'b0;
        step(2);
        up_raw = 1'b1;
        step(36);
        up_raw = 1'b0;
        step(20);
        check_drained("release_glitch");

        // up and down together: both dropped
        up_raw   = 1'b1;
        down_raw = 1'b1;
        step(10);
        up_raw   = 1'b0;
        down_raw = 1'b0;
        step(20);
        check_drained("up_down_conflict");

        // select wins, then locks out up until fully released
        b = edge_cnt + 1;
        slct_raw = 1'b1;
        up_raw   = 1'b1;
        expect_pulse(2, b + 7);
        expect_pulse(0, b + 37);
        expect_pulse(0, b + 46);
        step(30);
        slct_raw = 1'b0;
        step(20);
        up_raw = 1'b0;
        step(20);
        check_drained("slct_lockout");

        // Key held across enable rise stays unarmed until re-pressed
        enable = 1'b0;
        up_raw = 1'b1;
        step(1);
        check_idle("enable_low");
        step(9);
        enable = 1'b1;
        step(30);
        up_raw = 1'b0;
        step(10);
        b = edge_cnt + 1;
        up_raw = 1'b1;
        expect_pulse(0, b + 7);
        step(10);
        up_raw = 1'b0;
        step(20);
        check_drained("enable_arming");

        // Reset while in REPEAT
        b = edge_cnt + 1;
        up_raw = 1'b1;
        expect_pulse(0, b + 7);
        expect_pulse(0, b + 28);
        step(33);
        reset  = 1'b1;
        up_raw = 1'b0;
        step(1);
        check_idle("reset_mid_repeat");
        step(4);
        reset = 1'b0;
        step(20);
        check_drained("reset_recovery");

        check_drained("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/menu_key_pulser.md
Name: menu_key_pulser

Overview:
- Transmitter side of the menu key interface: converts raw held-level key signals from the keyboard decoder into clean active-low single-cycle press pulses.
- Outputs up_keyN, down_keyN and slct_keyN feed the menu screen's key inputs directly.
- Per-key processing: input synchronisation, press/release debounce, auto-repeat for up/down, select lockout and conflict arbitration.
- Guarantees the menu sees exactly one cycle low per accepted press or repeat, never a held level.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synced cycles required to accept a press or release (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles from the initial up/down pulse to the first repeat pulse.
- REPEAT_PERIOD, 7500000: cycles between subsequent repeat pulses.
- CNT_W, 25: width of each per-key counter; all three counts above must be ≤ 2^CNT_W − 1.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: menu active (driven from the menu's screen_on); low forces idle.
- up_raw, in, 1: up key held level, active-high, asynchronous to clk.
- down_raw, in, 1: down key held level, active-high, asynchronous.
- slct_raw, in, 1: select key held level, active-high, asynchronous.
- up_keyN, out, 1: up press pulse, active-low, one cycle.
- down_keyN, out, 1: down press pulse, active-low, one cycle.
- slct_keyN, out, 1: select press pulse, active-low, one cycle.

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset: all key outputs = 1, all FSMs = IDLE, counters = 0, synchronisers = 0, arm flags = 0.
- Each raw input passes through a 2-flop synchroniser. All logic below uses the synced value s.
- Per-key FSM states:
  - IDLE: s=1 → PRESS_DB with cnt=1.
  - PRESS_DB: s=1 → cnt++. When cnt reaches DEBOUNCE_CYCLES → HELD, cnt=0, and a pulse request is raised if armed. s=0 → IDLE, cnt=0.
  - HELD: up/down only — cnt++; at cnt=REPEAT_DELAY → REPEAT, cnt=0, pulse request. select stays in HELD with no repeat. s=0 → REL_DB with cnt=1.
  - REPEAT: cnt++; at cnt=REPEAT_PERIOD → cnt=0, pulse request. s=0 → REL_DB with cnt=1.
  - REL_DB: s=0 → cnt++; at cnt=DEBOUNCE_CYCLES → IDLE. s=1 → return to the prior held state (HELD or REPEAT) with cnt=0, no pulse. The glitch does not restart the delay counting beyond the reset to 0.
- Output timing: the output is registered. The pulse drives low in the cycle after the request and returns high the next cycle. A low pulse is never longer than 1 cycle.
- Latency: raw rises before edge 0 and stays high → keyN low exactly in cycle 2 + DEBOUNCE_CYCLES + 1 (edges 0-based).
- Arming: a key is armed only if it entered PRESS_DB while enable=1. A key already held when enable rises produces no pulse until released to IDLE and pressed again.
- enable=0: all FSMs → IDLE, outputs = 1, counters = 0 on the same edge; arm flags cleared.
- Arbitration, per cycle, on the requests:
  - slct request wins: only slct pulses, and up/down requests are dropped.
  - While the select FSM is in HELD or REL_DB, up/down requests are dropped (select lockout).
  - up and down requests in the same cycle: both dropped.
  - Dropped requests are not queued.
- Counters saturate; they never wrap while in any state.
- Reset mid-operation (e.g., mid-REPEAT) returns everything to reset values on that edge; no pulse follows.

Test Plan:
Params DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; enable=1 unless stated.

1. Single press: up_raw high from edge 0 for 10 cycles, then low → up_keyN low only in cycle 7; no other pulses; FSM back to IDLE by cycle ~17.
2. Bounce rejection: down_raw toggles 1,1,0,1,1,1,0 each cycle, then stays low → down_keyN never goes low.
3. Auto-repeat: down_raw held 60 cycles → down_keyN low at cycles 7, 28, 37, 46, 55 (initial, then +21, then every 9); slct_raw held 60 cycles → exactly one pulse at cycle 7.
4. Release glitch: up held 12 cycles, low 2 cycles, high again → no second pulse; repeat counting continues from HELD with cnt=0.
5. Conflicts:
   - up and down both raised on the same edge → no pulse on either output.
   - slct and up raised together → only slct_keyN pulses; up pulses stay suppressed until slct has fully released.
6. Enable/reset:
   - up held while enable=0, enable rises at cycle 10 → no pulse until up is released ≥4 cycles and pressed again.
   - reset asserted in REPEAT → all outputs 1 on the next edge; no pulses while reset is high.
